// File: rtl/pipes.sv
// Shared pipeline types: trap FSM states, privilege encodings, interrupt codes
// and the mstatus / exception-write-port layouts used between trap_ctrl and the CSR file.
package pipes;

    localparam logic [1:0]  PRIV_M   = 2'b11;
    localparam logic [1:0]  PRIV_U   = 2'b00;
    localparam logic [63:0] IRQ_MASK = 64'h888;

    localparam int MCAUSE_MSI = 3;
    localparam int MCAUSE_MTI = 7;
    localparam int MCAUSE_MEI = 11;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        CAPTURE,
        COMMIT,
        REDIRECT
    } trap_state_t;

    typedef struct packed {
        logic [50:0] hi;        // [63:13]
        logic [1:0]  mpp;       // [12:11]
        logic [2:0]  rsv_10_8;  // [10:8]
        logic        mpie;      // [7]
        logic [2:0]  rsv_6_4;   // [6:4]
        logic        mie;       // [3]
        logic [2:0]  rsv_2_0;   // [2:0]
    } mstatus_t;

    typedef struct packed {
        logic        enable;
        logic        mret;
        mstatus_t    mstatus;
        logic [63:0] mcause;
        logic [63:0] mepc;
    } excep_data_t;

endpackage

// File: rtl/trap_vec_calc.sv
// Fetch redirect target for trap entry / mret from latched mtvec, mepc and cause.
module trap_vec_calc #(
    parameter int MCAUSE_W = 4
) (
    input  logic [63:0]         i_mtvec,
    input  logic [63:0]         i_mepc,
    input  logic                i_is_mret,
    input  logic                i_is_irq,
    input  logic [MCAUSE_W-1:0] i_code,
    output logic [63:0]         o_pc
);

    logic [63:0] w_base;
    logic        w_vectored;

    assign w_base     = {i_mtvec[63:2], 2'b00};
    // Modes 2 and 3 are reserved and fall back to direct mode.
    assign w_vectored = (i_mtvec[1:0] == 2'b01);

    always_comb begin
        o_pc = w_base;
        if (i_is_mret) begin
            o_pc = i_mepc;
        end else if (w_vectored && i_is_irq) begin
            o_pc = w_base + (64'(i_code) << 2);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap-entry / mret sequencer: accept, drain memory, capture CSRs, commit the
// exception write, then redirect fetch and flush younger stages.
module trap_ctrl
    import pipes::*;
#(
    parameter int MCAUSE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                exc_valid,
    input  logic [MCAUSE_W-1:0] exc_code,
    input  logic [63:0]         exc_pc,
    input  logic                mret_valid,
    input  logic [63:0]         csr_mie,
    input  logic [63:0]         csr_mip,
    input  logic [63:0]         csr_mtvec,
    input  logic [63:0]         csr_mepc,
    input  logic                mem_busy,
    output logic                excep_readstatus,
    input  mstatus_t            excep_mstatus,
    output excep_data_t         excep_wdata,
    output logic                stall_commit,
    output logic                redirect_valid,
    output logic [63:0]         redirect_pc,
    output logic                flush,
    output logic [1:0]          priv_mode
);

    trap_state_t         r_state;
    trap_state_t         w_state_next;
    logic                r_is_mret;
    logic                r_is_irq;
    logic [MCAUSE_W-1:0] r_code;
    logic [63:0]         r_pc;
    logic [63:0]         r_mtvec;
    logic [63:0]         r_mepc;
    mstatus_t            r_mstatus;
    logic [1:0]          r_priv;

    logic [63:0]         w_pend;
    logic                w_irq;
    logic [MCAUSE_W-1:0] w_irq_code;
    logic                w_accept;
    mstatus_t            w_new_ms;
    logic [63:0]         w_vec_pc;

    assign w_pend   = csr_mie & csr_mip & IRQ_MASK;
    assign w_irq    = excep_mstatus.mie & (|w_pend);
    assign w_accept = w_irq | exc_valid | mret_valid;

    // Fixed machine-level priority: external, then software, then timer.
    always_comb begin
        w_irq_code = MCAUSE_W'(MCAUSE_MTI);
        if (w_pend[3])  w_irq_code = MCAUSE_W'(MCAUSE_MSI);
        if (w_pend[11]) w_irq_code = MCAUSE_W'(MCAUSE_MEI);
    end

    always_comb begin
        w_new_ms = r_mstatus;
        if (r_is_mret) begin
            w_new_ms.mie  = r_mstatus.mpie;
            w_new_ms.mpie = 1'b1;
            w_new_ms.mpp  = PRIV_U;
        end else begin
            w_new_ms.mpie = r_mstatus.mie;
            w_new_ms.mie  = 1'b0;
            w_new_ms.mpp  = r_priv;
        end
    end

    trap_vec_calc #(
        .MCAUSE_W (MCAUSE_W)
    ) u_vec (
        .i_mtvec   (r_mtvec),
        .i_mepc    (r_mepc),
        .i_is_mret (r_is_mret),
        .i_is_irq  (r_is_irq),
        .i_code    (r_code),
        .o_pc      (w_vec_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        excep_readstatus = 1'b0;
        stall_commit     = 1'b1;
        redirect_valid   = 1'b0;
        flush            = 1'b0;
        redirect_pc      = '0;
        excep_wdata      = '0;
        case (r_state)
            IDLE: begin
                excep_readstatus = 1'b1;
                stall_commit     = 1'b0;
                if (w_accept) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (!mem_busy) w_state_next = CAPTURE;
            end
            CAPTURE: begin
                excep_readstatus = 1'b1;
                w_state_next     = COMMIT;
            end
            COMMIT: begin
                excep_wdata.enable  = 1'b1;
                excep_wdata.mret    = r_is_mret;
                excep_wdata.mstatus = w_new_ms;
                if (!r_is_mret) begin
                    excep_wdata.mcause = {r_is_irq, 63'(r_code)};
                    excep_wdata.mepc   = r_pc;
                end
                w_state_next = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                redirect_pc    = w_vec_pc;
                w_state_next   = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_mret <= 1'b0;
            r_is_irq  <= 1'b0;
            r_code    <= '0;
            r_pc      <= '0;
            r_mtvec   <= '0;
            r_mepc    <= '0;
            r_mstatus <= '0;
            r_priv    <= PRIV_M;
        end else begin
            if (r_state == IDLE && w_accept) begin
                r_is_irq  <= w_irq;
                r_is_mret <= !w_irq && !exc_valid;
                r_code    <= w_irq ? w_irq_code : exc_code;
                r_pc      <= exc_pc;
            end
            if (r_state == CAPTURE) begin
                r_mstatus <= excep_mstatus;
                r_mtvec   <= csr_mtvec;
                r_mepc    <= csr_mepc;
            end
            if (r_state == COMMIT) begin
                r_priv <= r_is_mret ? r_mstatus.mpp : PRIV_M;
            end
        end
    end

    assign priv_mode = r_priv;

endmodule
